uart_rx: RTL

- UART receiver that consumes the serial line driven by the UART transmitter.
- Frame format, LSB first: start bit (0), 8 data bits, optional parity bit, stop bit (1).
- Synchronises the line, samples each bit at mid-bit, checks parity and stop bit, and pushes each byte plus its status into a 4-entry first-word-fall-through (FWFT) receive FIFO.
- Downstream logic reads the FIFO with a read-enable handshake.

---
 rtl/uart_rx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with a 2-flop line synchroniser, mid-bit sampling,
// parity/stop checking and a small first-word-fall-through receive FIFO.
// Ports: clk, rst (async, active-low), Rx (serial in, idle high),
//   Rd_en (pop head), Clr_ovr (clear Overrun);
//   Data_Out/Parity_err/Frame_err show the FIFO head, Data_valid = not empty,
//   Overrun (sticky drop flag), FIFO_full, Rx_busy (FSM not idle).
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    input  logic       Rd_en,
    input  logic       Clr_ovr,
    output logic [7:0] Data_Out,
    output logic       Data_valid,
    output logic       Parity_err,
    output logic       Frame_err,
    output logic       Overrun,
    output logic       FIFO_full,
    output logic       Rx_busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);
    localparam logic          PAR_EN   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // synchroniser
    logic r_sync1;
    logic r_sync2;
    logic w_rx_s;

    // receive FSM and datapath
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_pbit;
    logic          w_sample;
    logic          w_push;
    logic          w_perr;
    logic          w_ferr;

    // FIFO
    logic [9:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_ovr;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_wr;
    logic        w_drop;
    logic [9:0]  w_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= Rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s   = r_sync2;
    assign w_sample = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_perr      = PAR_EN & (((^r_shift) ^ r_pbit) != PAR_ODD);
        w_ferr      = ~w_rx_s;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = (HALF == 0) ? S_DATA : S_START;
                end
            end
            S_START: begin
                // a start bit that is high again at mid-bit was a glitch
                if (w_sample) begin
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_sample && r_bit_idx == 3'd7) begin
                    w_state_nxt = PAR_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_sample) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_sample) begin
                    w_push      = 1'b1;
                    w_state_nxt = w_ferr ? S_BREAK : S_IDLE;
                end
            end
            S_BREAK: begin
                // wait out a held-low line so it yields a single entry
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // In IDLE the counter is preloaded every cycle so it already holds
    // the right value on the edge that leaves IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_pbit    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_bit_idx <= '0;
            r_cnt     <= (HALF == 0) ? CNT_BIT : CNT_HALF;
        end else if (w_sample) begin
            r_cnt <= CNT_BIT;
            if (r_state == S_DATA) begin
                r_shift[r_bit_idx] <= w_rx_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
            if (r_state == S_PARITY) begin
                r_pbit <= w_rx_s;
            end
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign Rx_busy = (r_state != S_IDLE);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop   = Rd_en & ~w_empty;
    // a simultaneous pop frees the slot, so a push into a full FIFO is kept
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovr    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {w_ferr, w_perr, r_shift};
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (Clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign Data_Out   = w_head[7:0];
    assign Parity_err = w_head[8];
    assign Frame_err  = w_head[9];
    assign Data_valid = ~w_empty;
    assign FIFO_full  = w_full;
    assign Overrun    = r_ovr;

endmodule
